regular_ni_packetizer: RTL and testbench
========================================

// Module: regular_ni_packetizer
// PURPOSE
//  Downstream stage of the regular-NI FIFO. Pops 16-bit words from that FIFO:
//  tag words [15:13]=000 {core,slot} alternate with data words [15:13]=110.
//  Wraps them into a head/body/tail packet, injects flits into the local router
//  port under credit flow control, and closes short packets on a FIFO-idle timeout.
// PARAMETERS
//  SINK_ADDR      4'd0  destination router address written into the head flit
//  PAIRS_PER_PKT  4     tag/data word pairs per full packet (1..127)
//  CREDITS        4     router input-buffer depth; initial/maximum credit count
//  TIMEOUT        255   FIFO-empty cycles (1..255) before a partial packet is closed
// PORTS
//  clk_division  in   1   clock (two-divided system clock)
//  rst           in   1   synchronous, active-low reset
//  core_address  in   4   local core address, placed in the head flit
//  fifo_empty    in   1   regular-NI FIFO empty flag
//  fifo_data     in   16  FIFO read data, valid the cycle after fifo_rd
//  fifo_rd       out  1   FIFO pop strobe (combinational decode of state)
//  credit_in     in   1   one-cycle pulse: router freed one buffer slot
//  flit_out      out  18  {type[1:0],payload[15:0]}; type 01 head, 00 body, 10 tail
//  flit_valid    out  1   flit_out valid; high exactly one cycle per flit
//  pkt_sent      out  1   one-cycle pulse, coincident with the tail flit
//  err_seq       out  1   sticky: FIFO word tag out of expected alternation
// BEHAVIOUR
//  Reset: rst==0 at an edge -> state IDLE.
//  - Reset values: flit_out=0, flit_valid=0, pkt_sent=0, err_seq=0.
//  - Internal: credit=CREDITS, word_cnt=0, idle_tmr=0. fifo_rd=0 while rst==0.
//  - A word fetched but not yet emitted is dropped.
//  All outputs except fifo_rd are registered.
//  States and transitions:
//  - IDLE:  !fifo_empty && credit>0 -> HEAD.
//  - HEAD:  next cycle flit_out={01,3'b001,5'd0,SINK_ADDR,core_address}; -> FETCH.
//  - FETCH: fifo_rd=1 iff !fifo_empty && credit>0; when set, idle_tmr=0 and -> WAITD.
//           When fifo_empty, idle_tmr++; when idle_tmr==TIMEOUT -> TAIL.
//           (FETCH is only entered after a word has been sent, so word_cnt>=1 there.)
//           When !fifo_empty && credit==0, stay in FETCH and hold idle_tmr.
//  - WAITD: capture fifo_data; next cycle flit_out={00,fifo_data}.
//           word_cnt++. If word_cnt(new)==2*PAIRS_PER_PKT -> TAIL, else -> FETCH.
//  - TAIL:  stall while credit==0. Else next cycle flit_out={10,3'b111,5'd0,word_cnt[7:0]}
//           with pkt_sent=1; word_cnt=0; -> IDLE.
//  Latency:
//  - fifo_rd to body flit_valid = 2 cycles.
//  - IDLE exit to head flit_valid = 2 cycles.
//  Tag check in WAITD:
//  - Even word_cnt (before increment) expects [15:13]=000; odd expects 110.
//  - A mismatch or any other tag sets err_seq.
//  - The word is still forwarded unchanged; err_seq is cleared only by reset.
//  Credits:
//  - Each flit_valid decrements credit; credit_in increments it.
//  - Both in the same cycle: credit unchanged.
//  - credit_in at credit==CREDITS is ignored (saturate).
//  - credit never underflows: no flit is scheduled with credit==0.
//  Widths: word_cnt 8 bit, idle_tmr 8 bit, credit $clog2(CREDITS+1) bit.
// TESTING
//  Setup for all tests: SINK_ADDR=0, core_address=5, PAIRS_PER_PKT=2.
//  1 rst=0 for 2 cycles mid-activity -> all outputs 0, fifo_rd=0; after release first head needs 4 credits of headroom.
//  2 FIFO holds 0013,C000,0014,C001, credits ample -> flits 12005,00013,0C000,00014,0C001,2E004; pkt_sent with last.
//  3 CREDITS=2, no credit_in, FIFO full -> head+1 body only, fifo_rd stays 0; one credit_in pulse -> exactly one more body.
//  4 FIFO gives 0013,C000 then stays empty -> after 255 empty FETCH cycles tail 2E002 + pkt_sent; back to IDLE.
//  5 FIFO words 0013 then 0014 -> err_seq=1 the cycle the 2nd body flit (00014) is valid; stays 1 until rst=0.
//  6 rst=0 one cycle during WAITD -> no body flit emitted, credit restored to CREDITS, next packet starts with head.

Source files
------------

// File: rtl/regular_ni_packetizer_if.sv
// Regular-NI packetizer bus bundle: FIFO read side plus local router injection port.
interface regular_ni_packetizer_if;
   logic [3:0]  core_address;
   logic        fifo_empty;
   logic [15:0] fifo_data;
   logic        fifo_rd;
   logic        credit_in;
   logic [17:0] flit_out;
   logic        flit_valid;
   logic        pkt_sent;
   logic        err_seq;

   // Packetizer side: consumes FIFO words and credits, produces flits.
   modport master (
      input  core_address,
      input  fifo_empty,
      input  fifo_data,
      input  credit_in,
      output fifo_rd,
      output flit_out,
      output flit_valid,
      output pkt_sent,
      output err_seq
   );

   // Environment side: FIFO and router.
   modport slave (
      output core_address,
      output fifo_empty,
      output fifo_data,
      output credit_in,
      input  fifo_rd,
      input  flit_out,
      input  flit_valid,
      input  pkt_sent,
      input  err_seq
   );
endinterface

// File: rtl/regular_ni_packetizer.sv
// Regular-NI packetizer: pops tag/data words from the NI FIFO, wraps them into
// head/body/tail flits for the local router port under credit flow control,
// and closes partial packets after a FIFO-idle timeout.
module regular_ni_packetizer #(
   parameter logic [3:0]  SINK_ADDR     = 4'd0,
   parameter int unsigned PAIRS_PER_PKT = 4,
   parameter int unsigned CREDITS       = 4,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic                     clk_division,
   input  logic                     rst,
   regular_ni_packetizer_if.master  bus
);

   localparam int unsigned CW            = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CREDIT_MAX  = CW'(CREDITS);
   localparam logic [7:0] WORDS_PER_PKT  = 8'(2 * PAIRS_PER_PKT);
   localparam logic [7:0] TMR_LIMIT      = 8'(TIMEOUT);
   localparam logic [2:0] TAG_TAG_WORD   = 3'b000;
   localparam logic [2:0] TAG_DATA_WORD  = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEAD,
      S_FETCH,
      S_WAITD,
      S_TAIL
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_credit;
   logic [7:0]      r_word_cnt;
   logic [7:0]      r_idle_tmr;
   logic [17:0]     r_flit_out;
   logic            r_flit_valid;
   logic            r_pkt_sent;
   logic            r_err_seq;

   logic            w_has_credit;
   logic            w_fetch;
   logic            w_flit_sched;
   logic [2:0]      w_tag_exp;
   logic [7:0]      w_word_cnt_inc;
   logic [7:0]      w_tmr_inc;

   assign w_has_credit   = (r_credit != '0);
   // Pop only when a word is there and a buffer slot is guaranteed for its body flit.
   assign w_fetch        = rst && (r_state == S_FETCH) && !bus.fifo_empty && w_has_credit;
   // A flit leaves on the edge closing HEAD, WAITD, or a credited TAIL cycle.
   assign w_flit_sched   = (r_state == S_HEAD) || (r_state == S_WAITD) ||
                           ((r_state == S_TAIL) && w_has_credit);
   assign w_tag_exp      = r_word_cnt[0] ? TAG_DATA_WORD : TAG_TAG_WORD;
   assign w_word_cnt_inc = r_word_cnt + 8'd1;
   assign w_tmr_inc      = r_idle_tmr + 8'd1;

   assign bus.fifo_rd    = w_fetch;
   assign bus.flit_out   = r_flit_out;
   assign bus.flit_valid = r_flit_valid;
   assign bus.pkt_sent   = r_pkt_sent;
   assign bus.err_seq    = r_err_seq;

   // Credit counter: one per flit sent, one per router release, saturating at the buffer depth.
   always_ff @(posedge clk_division) begin
      if (!rst) begin
         r_credit <= CREDIT_MAX;
      end else if (w_flit_sched && !bus.credit_in) begin
         r_credit <= r_credit - CW'(1);
      end else if (!w_flit_sched && bus.credit_in && (r_credit != CREDIT_MAX)) begin
         r_credit <= r_credit + CW'(1);
      end
   end

   // Packet FSM with registered flit outputs, word counter, idle timer and sequence check.
   always_ff @(posedge clk_division) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_word_cnt   <= 8'd0;
         r_idle_tmr   <= 8'd0;
         r_flit_out   <= 18'd0;
         r_flit_valid <= 1'b0;
         r_pkt_sent   <= 1'b0;
         r_err_seq    <= 1'b0;
      end else begin
         r_flit_valid <= 1'b0;
         r_pkt_sent   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!bus.fifo_empty && w_has_credit) begin
                  r_state <= S_HEAD;
               end
            end
            S_HEAD: begin
               r_flit_out   <= {2'b01, 3'b001, 5'd0, SINK_ADDR, bus.core_address};
               r_flit_valid <= 1'b1;
               r_idle_tmr   <= 8'd0;
               r_state      <= S_FETCH;
            end
            S_FETCH: begin
               if (w_fetch) begin
                  r_idle_tmr <= 8'd0;
                  r_state    <= S_WAITD;
               end else if (bus.fifo_empty) begin
                  // Idle cycles close a partial packet; a credit stall alone does not.
                  if (w_tmr_inc == TMR_LIMIT) begin
                     r_idle_tmr <= 8'd0;
                     r_state    <= S_TAIL;
                  end else begin
                     r_idle_tmr <= w_tmr_inc;
                  end
               end
            end
            S_WAITD: begin
               r_flit_out   <= {2'b00, bus.fifo_data};
               r_flit_valid <= 1'b1;
               if (bus.fifo_data[15:13] != w_tag_exp) begin
                  r_err_seq <= 1'b1;
               end
               r_word_cnt <= w_word_cnt_inc;
               r_state    <= (w_word_cnt_inc == WORDS_PER_PKT) ? S_TAIL : S_FETCH;
            end
            S_TAIL: begin
               if (w_has_credit) begin
                  r_flit_out   <= {2'b10, 3'b111, 5'd0, r_word_cnt};
                  r_flit_valid <= 1'b1;
                  r_pkt_sent   <= 1'b1;
                  r_word_cnt   <= 8'd0;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regular_ni_packetizer.sv
// Bench for regular_ni_packetizer: FIFO model, credit return and flit scoreboard.
module tb_regular_ni_packetizer;

   localparam logic [17:0] HEAD_FLIT = {2'b01, 3'b001, 5'd0, 4'd0, 4'd5};

   typedef struct packed {
      logic [15:0] din;
      logic [17:0] exp_body;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;

   regular_ni_packetizer_if bus_a ();
   regular_ni_packetizer_if bus_b ();

   regular_ni_packetizer #(.SINK_ADDR(4'd0), .PAIRS_PER_PKT(2), .CREDITS(4), .TIMEOUT(255))
      dut_a (.clk_division(clk), .rst(rst_a), .bus(bus_a));

   regular_ni_packetizer #(.SINK_ADDR(4'd0), .PAIRS_PER_PKT(2), .CREDITS(2), .TIMEOUT(255))
      dut_b (.clk_division(clk), .rst(rst_b), .bus(bus_b));

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] fq[$];
   logic [17:0] sb[$];
   logic [17:0] b_flits[$];
   logic        sb_en   = 1'b1;
   logic        auto_cr = 1'b0;
   logic        pend_cr = 1'b0;
   logic        man_cr  = 1'b0;
   logic        b_pulse = 1'b0;
   logic [15:0] b_word  = 16'h0013;
   int          rd_b_cnt = 0;
   vec_t        vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      fq.push_back(w);
      bus_a.fifo_empty = 1'b0;
   endtask

   // One clock: FIFO pops on the edge after fifo_rd, flits checked on the falling edge.
   task automatic tick();
      logic rd_a;
      logic rd_b;
      logic [17:0] e;
      rd_a = bus_a.fifo_rd;
      rd_b = bus_b.fifo_rd;
      bus_a.credit_in = (auto_cr && pend_cr) || man_cr;
      bus_b.credit_in = b_pulse;
      @(posedge clk);
      #1;
      if (rd_a && fq.size() > 0) bus_a.fifo_data = fq.pop_front();
      bus_a.fifo_empty = (fq.size() == 0);
      if (rd_b) begin
         bus_b.fifo_data = b_word;
         b_word = (b_word == 16'h0013) ? 16'hC000 : 16'h0013;
         rd_b_cnt++;
      end
      bus_a.credit_in = 1'b0;
      bus_b.credit_in = 1'b0;
      man_cr  = 1'b0;
      b_pulse = 1'b0;
      @(negedge clk);
      pend_cr = bus_a.flit_valid;
      if (bus_b.flit_valid) b_flits.push_back(bus_b.flit_out);
      if (sb_en && bus_a.flit_valid) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_flit: got %0h expected none", bus_a.flit_out);
         end else begin
            e = sb.pop_front();
            if (bus_a.flit_out !== e || bus_a.pkt_sent !== (e[17:16] == 2'b10)) begin
               n_fail++;
               $display("FAIL flit: got %0h pkt_sent %0b expected %0h pkt_sent %0b",
                        bus_a.flit_out, bus_a.pkt_sent, e, (e[17:16] == 2'b10));
            end
         end
      end
      if (bus_a.pkt_sent && !bus_a.flit_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL pkt_sent_alone: got 1 expected 0");
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drain(input string name, input int budget);
      int t;
      t = 0;
      while (sb.size() > 0 && t < budget) begin
         tick();
         t++;
      end
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   task automatic reset_a(input int n);
      rst_a = 1'b0;
      auto_cr = 1'b0;
      ticks(n);
      fq.delete();
      sb.delete();
      bus_a.fifo_empty = 1'b1;
      rst_a = 1'b1;
      auto_cr = 1'b1;
   endtask

   initial begin
      int t;
      int s;
      logic seen;
      vecs[0] = '{din: 16'h0013, exp_body: 18'h00013};
      vecs[1] = '{din: 16'hC000, exp_body: 18'h0C000};
      vecs[2] = '{din: 16'h0014, exp_body: 18'h00014};
      vecs[3] = '{din: 16'hC001, exp_body: 18'h0C001};
      vecs[4] = '{din: 16'h1FFF, exp_body: 18'h01FFF};
      vecs[5] = '{din: 16'hDFFF, exp_body: 18'h0DFFF};
      vecs[6] = '{din: 16'h0000, exp_body: 18'h00000};
      vecs[7] = '{din: 16'hC0AB, exp_body: 18'h0C0AB};

      rst_a = 1'b0;
      rst_b = 1'b0;
      bus_a.core_address = 4'd5;
      bus_b.core_address = 4'd5;
      bus_a.fifo_empty = 1'b1;
      bus_b.fifo_empty = 1'b1;
      bus_a.fifo_data = 16'h0;
      bus_b.fifo_data = 16'h0;
      bus_a.credit_in = 1'b0;
      bus_b.credit_in = 1'b0;
      @(negedge clk);
      ticks(3);

      // Reset state
      chk("rst_flit_out", 32'(bus_a.flit_out), 32'd0);
      chk("rst_flit_valid", 32'(bus_a.flit_valid), 32'd0);
      chk("rst_pkt_sent", 32'(bus_a.pkt_sent), 32'd0);
      chk("rst_err_seq", 32'(bus_a.err_seq), 32'd0);
      chk("rst_fifo_rd", 32'(bus_a.fifo_rd), 32'd0);
      chk("rst_b_outputs", {bus_b.flit_out, bus_b.flit_valid, bus_b.pkt_sent, bus_b.err_seq, bus_b.fifo_rd}, 32'd0);

      // Two full packets from the vector table, credits returned as flits leave
      rst_a = 1'b1;
      auto_cr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i % 4 == 0) sb.push_back(HEAD_FLIT);
         push_word(vecs[i].din);
         sb.push_back(vecs[i].exp_body);
         if (i % 4 == 3) sb.push_back(18'h2E004);
      end
      drain("table_packets", 80);
      chk("table_err_seq", 32'(bus_a.err_seq), 32'd0);

      // Reset mid-packet: outputs cleared, then exactly CREDITS flits without returns
      sb_en = 1'b0;
      for (int i = 0; i < 4; i++) push_word(vecs[i].din);
      ticks(6);
      rst_a = 1'b0;
      auto_cr = 1'b0;
      ticks(2);
      chk("midrst_outputs", {bus_a.flit_out, bus_a.flit_valid, bus_a.pkt_sent, bus_a.err_seq}, 32'd0);
      chk("midrst_fifo_rd", 32'(bus_a.fifo_rd), 32'd0);
      fq.delete();
      bus_a.fifo_empty = 1'b1;
      rst_a = 1'b1;
      sb_en = 1'b1;
      for (int i = 0; i < 8; i++) push_word(vecs[i].din);
      sb.push_back(HEAD_FLIT);
      for (int i = 0; i < 3; i++) sb.push_back(vecs[i].exp_body);
      drain("credit_headroom", 40);
      ticks(20);
      chk("credit_stall_fifo_rd", 32'(bus_a.fifo_rd), 32'd0);
      reset_a(1);

      // Timeout closes a two-word packet, then the block returns to IDLE
      push_word(16'h0013);
      push_word(16'hC000);
      sb.push_back(HEAD_FLIT);
      sb.push_back(18'h00013);
      sb.push_back(18'h0C000);
      sb.push_back(18'h2E002);
      t = 0;
      while (sb.size() > 0 && t < 400) begin
         tick();
         t++;
      end
      chk("timeout_done", 32'(sb.size()), 32'd0);
      chk("timeout_window", 32'(t >= 255 && t <= 280), 32'd1);
      ticks(20);
      for (int i = 0; i < 4; i++) begin
         if (i == 0) sb.push_back(HEAD_FLIT);
         push_word(vecs[i].din);
         sb.push_back(vecs[i].exp_body);
      end
      sb.push_back(18'h2E004);
      drain("after_timeout_packet", 40);

      // Sequence error: sticky from the second body flit until reset
      push_word(16'h0013);
      push_word(16'h0014);
      push_word(16'hC000);
      push_word(16'hC001);
      sb.push_back(HEAD_FLIT);
      sb.push_back(18'h00013);
      sb.push_back(18'h00014);
      sb.push_back(18'h0C000);
      sb.push_back(18'h0C001);
      sb.push_back(18'h2E004);
      seen = 1'b0;
      t = 0;
      while (!seen && t < 30) begin
         tick();
         t++;
         if (bus_a.flit_valid && bus_a.flit_out == 18'h00013)
            chk("err_before", 32'(bus_a.err_seq), 32'd0);
         if (bus_a.flit_valid && bus_a.flit_out == 18'h00014) begin
            seen = 1'b1;
            chk("err_at_bad_word", 32'(bus_a.err_seq), 32'd1);
         end
      end
      chk("err_word_seen", 32'(seen), 32'd1);
      drain("err_packet", 40);
      ticks(5);
      chk("err_sticky", 32'(bus_a.err_seq), 32'd1);
      reset_a(1);
      chk("err_cleared", 32'(bus_a.err_seq), 32'd0);

      // Reset while a fetched word waits: it is dropped and credits return to full
      sb_en = 1'b0;
      for (int i = 0; i < 4; i++) push_word(vecs[i].din);
      t = 0;
      s = fq.size();
      while (fq.size() == s && t < 20) begin
         tick();
         t++;
      end
      chk("waitd_reached", 32'(fq.size()), 32'(s - 1));
      rst_a = 1'b0;
      auto_cr = 1'b0;
      tick();
      fq.delete();
      bus_a.fifo_empty = 1'b1;
      rst_a = 1'b1;
      sb_en = 1'b1;
      ticks(10);
      for (int i = 0; i < 4; i++) push_word(vecs[i].din);
      sb.push_back(HEAD_FLIT);
      for (int i = 0; i < 3; i++) sb.push_back(vecs[i].exp_body);
      drain("waitd_rst_headroom", 40);
      ticks(10);
      chk("waitd_rst_stalled", 32'(sb.size()), 32'd0);
      sb.push_back(18'h0C001);
      sb.push_back(18'h2E004);
      for (int i = 0; i < 4; i++) begin
         man_cr = 1'b1;
         tick();
      end
      drain("waitd_rst_finish", 40);

      // Two-credit instance: no returns means head plus one body, then one credit, one body
      rst_b = 1'b1;
      bus_b.fifo_empty = 1'b0;
      ticks(10);
      rd_b_cnt = 0;
      ticks(20);
      chk("b_flit_count", 32'(b_flits.size()), 32'd2);
      if (b_flits.size() >= 2) begin
         chk("b_head", 32'(b_flits[0]), 32'(HEAD_FLIT));
         chk("b_body0", 32'(b_flits[1]), 32'h00013);
      end
      chk("b_fifo_rd_idle", 32'(rd_b_cnt), 32'd0);
      b_pulse = 1'b1;
      ticks(30);
      chk("b_flit_count_after_credit", 32'(b_flits.size()), 32'd3);
      if (b_flits.size() >= 3) chk("b_body1", 32'(b_flits[2]), 32'h0C000);
      chk("b_fifo_rd_once", 32'(rd_b_cnt), 32'd1);
      rst_b = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
